hazard_ctrl: RTL

- Pipeline hazard controller in the ID stage. It generates the NoOp/stall request that the decode control unit consumes, plus PC-write and IF/ID-write enables and the branch flush.
- Keeps its own shadow scoreboard of destination registers in EX and MEM. This lets it detect read-after-write (RAW) hazards without tapping the downstream pipeline registers.
- Supports a forwarding build (load-use stall only) and a no-forwarding build (full RAW interlock against EX and MEM).
- Provides saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller.
// Keeps a small shadow copy of the destination registers held in EX and MEM.
// From that copy it raises the decode NoOp/stall, the PC and IF/ID write
// enables, the taken-branch flush, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned FORWARDING = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       Op_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             Branch_i,
  input  logic             Zero_i,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic use_rs1, use_rs2;
  logic ex_match, mem_match;
  logic stall, flush;

  // Work out which source operands the ID instruction actually reads.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (Op_i)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ITYPE, OP_LOAD: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Detect hazards against the shadows and derive the control outputs.
  always_comb begin
    ex_match  = ex_regwrite_q && (ex_rd_q != 5'd0) &&
                ((use_rs1 && (ex_rd_q == RS1addr_i)) ||
                 (use_rs2 && (ex_rd_q == RS2addr_i)));
    mem_match = mem_regwrite_q && (mem_rd_q != 5'd0) &&
                ((use_rs1 && (mem_rd_q == RS1addr_i)) ||
                 (use_rs2 && (mem_rd_q == RS2addr_i)));
    if (FORWARDING != 0) begin
      stall = ex_match && ex_memread_q;
    end else begin
      stall = ex_match || mem_match;
    end
    stall       = stall && !rst_i;
    flush       = Branch_i && Zero_i && !stall && !rst_i;
    NoOp_o      = stall;
    PCWrite_o   = !stall;
    IFIDWrite_o = !stall;
    Flush_o     = flush;
    StallCnt_o  = stall_cnt_q;
    FlushCnt_o  = flush_cnt_q;
  end

  // Advance the shadow pipeline and bump the saturating counters.
  always_comb begin
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    ex_rd_d        = RDaddr_i;
    ex_regwrite_d  = RegWrite_i;
    ex_memread_d   = MemRead_i;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (stall) begin
      ex_rd_d       = 5'd0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
    end
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

endmodule
